// File: rtl/banco_escrita_pkg.sv
// Shared constants and state type for the register-bank write side.
// Consumed by banco_escrita, its interface and the Decodificador10 decoder.
package banco_pkg;

    localparam int LARGURA_PADRAO  = 8;
    localparam int NUM_REGS_PADRAO = 10;
    localparam int ENDERECO_W      = 4;

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        LIMPANDO = 1'b1
    } estado_banco_t;

endpackage

// File: rtl/banco_escrita_if.sv
// Write/clear handshake between the calculator control FSM (master) and the bank (slave).
interface banco_escrita_if
    import banco_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
);

    logic                  Valido;
    logic                  Pronto;
    logic [ENDERECO_W-1:0] Endereco;
    logic [LARGURA-1:0]    Dado;
    logic                  Limpar;
    logic                  Ocupado;
    logic                  Erro;

    modport master (
        output Valido,
        output Endereco,
        output Dado,
        output Limpar,
        input  Pronto,
        input  Ocupado,
        input  Erro
    );

    modport slave (
        input  Valido,
        input  Endereco,
        input  Dado,
        input  Limpar,
        output Pronto,
        output Ocupado,
        output Erro
    );

endinterface

// File: rtl/banco_escrita_decodificador.sv
// Decodificador10: combinational address-to-one-hot write-enable decoder, shared by
// the write path and the clear sweep; invalido flags addresses beyond the last register.
module Decodificador10
    import banco_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_PADRAO
) (
    input  logic [ENDERECO_W-1:0] endereco,
    input  logic                  habilita,
    output logic [NUM_REGS-1:0]   habilitacao,
    output logic                  invalido
);

    always_comb begin
        habilitacao = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (habilita && (endereco == ENDERECO_W'(i))) begin
                habilitacao[i] = 1'b1;
            end
        end
        invalido = (endereco >= ENDERECO_W'(NUM_REGS));
    end

endmodule

// File: rtl/banco_escrita.sv
// Write side of the calculator register bank: handshaked writes, sequenced clear-all,
// parallel register outputs. Optional macro BANCO_REG0_ZERO_EN hardwires Reg0 to zero.
module banco_escrita
    import banco_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int NUM_REGS = NUM_REGS_PADRAO
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    banco_escrita_if.slave       barramento,
    output logic [LARGURA-1:0]   Reg0,
    output logic [LARGURA-1:0]   Reg1,
    output logic [LARGURA-1:0]   Reg2,
    output logic [LARGURA-1:0]   Reg3,
    output logic [LARGURA-1:0]   Reg4,
    output logic [LARGURA-1:0]   Reg5,
    output logic [LARGURA-1:0]   Reg6,
    output logic [LARGURA-1:0]   Reg7,
    output logic [LARGURA-1:0]   Reg8,
    output logic [LARGURA-1:0]   Reg9
);

    localparam logic [ENDERECO_W-1:0] ULTIMO = ENDERECO_W'(NUM_REGS - 1);

    estado_banco_t         estado, prox_estado;
    logic [ENDERECO_W-1:0] contador, prox_contador;
    logic [LARGURA-1:0]    regs [NUM_REGS];
    logic                  erro_q, ocupado_q;

    logic                  pronto, aceita;
    logic [ENDERECO_W-1:0] end_sel;
    logic [LARGURA-1:0]    dado_sel;
    logic                  habilita_dec;
    logic [NUM_REGS-1:0]   habilitacao, hab_efetiva;
    logic                  invalido;

    assign pronto             = (estado == OCIOSO) && !barramento.Limpar;
    assign aceita             = barramento.Valido && pronto;
    assign barramento.Pronto  = pronto;
    assign barramento.Ocupado = ocupado_q;
    assign barramento.Erro    = erro_q;

    Decodificador10 #(
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .endereco    (end_sel),
        .habilita    (habilita_dec),
        .habilitacao (habilitacao),
        .invalido    (invalido)
    );

    // The sweep reuses the decoder: while clearing, the counter replaces the
    // request address and zero replaces the request data.
    always_comb begin
        prox_estado   = estado;
        prox_contador = contador;
        end_sel       = barramento.Endereco;
        dado_sel      = barramento.Dado;
        habilita_dec  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (barramento.Limpar) begin
                    prox_estado   = LIMPANDO;
                    prox_contador = '0;
                end else begin
                    habilita_dec = aceita;
                end
            end
            LIMPANDO: begin
                end_sel      = contador;
                dado_sel     = '0;
                habilita_dec = 1'b1;
                if (contador == ULTIMO) begin
                    prox_estado   = OCIOSO;
                    prox_contador = '0;
                end else begin
                    prox_contador = contador + ENDERECO_W'(1);
                end
            end
            default: begin
                prox_estado   = OCIOSO;
                prox_contador = '0;
            end
        endcase
    end

    always_comb begin
        hab_efetiva = habilitacao;
`ifdef BANCO_REG0_ZERO_EN
        hab_efetiva[0] = 1'b0;
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            estado    <= OCIOSO;
            contador  <= '0;
            erro_q    <= 1'b0;
            ocupado_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            estado    <= prox_estado;
            contador  <= prox_contador;
            erro_q    <= aceita && invalido;
            ocupado_q <= (prox_estado == LIMPANDO);
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (hab_efetiva[i]) begin
                    regs[i] <= dado_sel;
                end
            end
        end
    end

`ifdef BANCO_REG0_ZERO_EN
    assign Reg0 = '0;
`else
    assign Reg0 = regs[0];
`endif
    assign Reg1 = regs[1];
    assign Reg2 = regs[2];
    assign Reg3 = regs[3];
    assign Reg4 = regs[4];
    assign Reg5 = regs[5];
    assign Reg6 = regs[6];
    assign Reg7 = regs[7];
    assign Reg8 = regs[8];
    assign Reg9 = regs[9];

endmodule

// File: tb/tb_banco_escrita.sv
// Scoreboard bench for banco_escrita: directed scenarios then randomized traffic,
// expected per-cycle outputs from a behavioural model queued for a negedge monitor.
module tb_banco_escrita;
    import banco_pkg::*;

    localparam int L = 8;
    localparam int N = 10;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    logic [L-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9;
    logic [N-1:0][L-1:0] regs_dut;

    banco_escrita_if #(.LARGURA(L)) barramento ();

    banco_escrita #(
        .LARGURA  (L),
        .NUM_REGS (N)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .barramento (barramento.slave),
        .Reg0 (r0), .Reg1 (r1), .Reg2 (r2), .Reg3 (r3), .Reg4 (r4),
        .Reg5 (r5), .Reg6 (r6), .Reg7 (r7), .Reg8 (r8), .Reg9 (r9)
    );

    always #5 Clock = ~Clock;

    assign regs_dut = {r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};

    typedef struct packed {
        logic [N-1:0][L-1:0] regs;
        logic                erro;
        logic                ocupado;
        logic                pronto;
    } esperado_t;

    esperado_t fila[$];
    int checks = 0;
    int errors = 0;

    // Reference model: register contents, remaining clear cycles, pending error flag.
    logic [L-1:0] modelo [N];
    int           limpa_rest = 0;
    logic         m_erro = 1'b0;

    function automatic bit reg_gravavel(input int a);
`ifdef BANCO_REG0_ZERO_EN
        return (a >= 1) && (a < N);
`else
        return (a >= 0) && (a < N);
`endif
    endfunction

    function void comparar(input string nome, input int unsigned atual, input int unsigned req);
        checks++;
        if (atual != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nome, $time, atual, req);
        end
    endfunction

    always @(negedge Clock) begin : monitor
        esperado_t e;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            comparar("pronto",  32'(barramento.Pronto),  32'(e.pronto));
            comparar("ocupado", 32'(barramento.Ocupado), 32'(e.ocupado));
            comparar("erro",    32'(barramento.Erro),    32'(e.erro));
            for (int k = 0; k < N; k++) begin
                comparar($sformatf("reg%0d", k), 32'(regs_dut[k]), 32'(e.regs[k]));
            end
        end
    end

    // One clock cycle: drive inputs, queue this cycle's expectation, then apply the edge to the model.
    task automatic ciclo(input logic rst, input logic v, input logic l,
                         input logic [3:0] a, input logic [L-1:0] d,
                         input bit registrar, output bit aceito);
        esperado_t e;
        bool_ignore: begin end
        Reset_n              = rst;
        barramento.Valido    = v;
        barramento.Limpar    = l;
        barramento.Endereco  = a;
        barramento.Dado      = d;
        aceito = v && (limpa_rest == 0) && !l;
        if (registrar) begin
            for (int k = 0; k < N; k++) e.regs[k] = modelo[k];
            e.erro    = m_erro;
            e.ocupado = (limpa_rest > 0);
            e.pronto  = (limpa_rest == 0) && !l;
            fila.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (!rst) begin
            for (int k = 0; k < N; k++) modelo[k] = '0;
            limpa_rest = 0;
            m_erro     = 1'b0;
            aceito     = 1'b0;
        end else if (limpa_rest > 0) begin
            modelo[N - limpa_rest] = '0;
            limpa_rest--;
            m_erro = 1'b0;
        end else if (l) begin
            limpa_rest = N;
            m_erro     = 1'b0;
        end else if (v) begin
            if (reg_gravavel(int'(a))) modelo[a] = d;
            m_erro = (int'(a) >= N);
        end else begin
            m_erro = 1'b0;
        end
    endtask

    task automatic ocioso(input int n);
        bit ac;
        for (int i = 0; i < n; i++) ciclo(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1, ac);
    endtask

    task automatic escreve(input logic [3:0] a, input logic [L-1:0] d);
        bit ac;
        ciclo(1'b1, 1'b1, 1'b0, a, d, 1'b1, ac);
    endtask

    initial begin : driver
        bit ac;
        bit pend_v;
        logic [3:0] pend_a;
        logic [L-1:0] pend_d;
        logic lim;
        logic rst;

        ciclo(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, ac);
        ciclo(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b1, ac);

        escreve(4'd3, 8'hA5);
        ocioso(1);

        for (int n = 0; n < N; n++) escreve(4'(n), 8'(8'h10 + n));
        ocioso(1);

        escreve(4'd12, 8'hFF);
        ocioso(2);
        escreve(4'd13, 8'h01);
        escreve(4'd15, 8'h02);
        ocioso(1);

        ciclo(1'b1, 1'b1, 1'b1, 4'd5, 8'h77, 1'b1, ac);
        ocioso(11);

        for (int n = 0; n < N; n++) escreve(4'(n), 8'(8'hC0 + n));
        ciclo(1'b1, 1'b0, 1'b1, 4'd0, '0, 1'b1, ac);
        ocioso(3);
        ciclo(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b1, ac);
        ocioso(2);
        escreve(4'd7, 8'h3C);
        ocioso(1);

        escreve(4'd0, 8'h55);
        ocioso(1);
        escreve(4'd0, 8'h66);
        escreve(4'd0, 8'h67);
        ocioso(1);

        pend_v = 1'b0;
        pend_a = '0;
        pend_d = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_a = 4'($urandom_range(0, 15));
                pend_d = 8'($urandom);
            end
            lim = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 149) != 0);
            ciclo(rst, pend_v, lim, pend_a, pend_d, 1'b1, ac);
            if (ac || !rst) pend_v = 1'b0;
        end

        ocioso(12);
        @(negedge Clock);
        #1;
        comparar("fila_vazia", 32'(fila.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_escrita.md
# banco_escrita

Write side of the calculator's 8-bit register bank: accepts write requests over a valid/ready handshake, decodes the 4-bit address to one of ten registers, and exposes all ten register values in parallel to the read multiplexer (`Mux16`), which selects one by its 4-bit select. Also provides a sequenced clear-all operation used when the calculator is cleared. Sits between the calculator control FSM (writer) and the read mux (reader).

## Interface
Parameters:
- `LARGURA`, 8: register width in bits.
- `NUM_REGS`, 10: number of registers; addresses `0..NUM_REGS-1` are valid.

Ports:
- `Clock`  in  1  single clock; all state changes on rising edge.
- `Reset_n`  in  1  **reset is synchronous and active-low**; sampled on the rising edge of `Clock`.
- `Valido`  in  1  write request valid.
- `Pronto`  out  1  block can accept a write this cycle.
- `Endereco`  in  4  write address.
- `Dado`  in  LARGURA  write data.
- `Limpar`  in  1  start clear-all sequence (level sampled while idle).
- `Ocupado`  out  1  clear sequence in progress.
- `Erro`  out  1  one-cycle pulse: last accepted write had an invalid address.
- `Reg0` … `Reg9`  out  LARGURA each  current register contents, direct to the read mux data inputs.

## Operation
- States: `OCIOSO`, `LIMPANDO`.
- `Pronto` = (state == `OCIOSO`) && !`Limpar`, combinational.
- Write accepted on an edge where `Valido && Pronto`. If `Endereco < NUM_REGS`, the addressed register takes `Dado`; other registers hold.
- Accepted write with `Endereco` in 10..15: no register changes; `Erro` = 1 for the following cycle only.
- `Valido` without `Pronto`: nothing happens. The writer holds `Valido`/`Endereco`/`Dado` until accepted.
- `OCIOSO` and `Limpar` = 1: go to `LIMPANDO` and load the sweep counter with 0. `Limpar` has priority over a simultaneous `Valido`; that write is not accepted.
- `LIMPANDO`: each cycle, write 0 to the register indexed by the counter, then increment. After index 9 is written, return to `OCIOSO`. `Limpar` and `Valido` are ignored throughout.
- Counter width is 4 bits and never exceeds 9.

## Timing
- Reset (`Reset_n` = 0 at an edge):
  - `Reg0`–`Reg9` = 0, state = `OCIOSO`, counter = 0, `Erro` = 0, `Ocupado` = 0.
  - `Pronto` follows its equation (1 unless `Limpar` is high).
- Write latency: the new value is visible on `RegN` in the cycle after the accepting edge. Back-to-back writes are accepted every cycle.
- Same-address writes on consecutive cycles: the last one wins.
- `Ocupado` is registered: high from the cycle after `Limpar` is sampled through the cycle in which `Reg9` is cleared. That is exactly 10 cycles.
- `Pronto` goes high again in the cycle after the last clear write.
- `Erro` is registered: asserted exactly 1 cycle, the cycle after the accepting edge. Back-to-back invalid writes keep it high for consecutive cycles.
- Reset mid-clear: all registers go to 0 immediately, state `OCIOSO`, no residual sweep.

## Configuration
- `BANCO_REG0_ZERO_EN` defined:
  - `Reg0` is hardwired to 0.
  - Writes to address 0 are accepted, discarded, and do not raise `Erro`.
  - The clear sweep still takes 10 cycles.
- Undefined: `Reg0` is an ordinary writable register.

## Structure
- Package `banco_pkg` holds:
  - `LARGURA_PADRAO` = 8 and `NUM_REGS_PADRAO` = 10 constants.
  - `estado_banco_t` enum (`OCIOSO`, `LIMPANDO`).
  - `ENDERECO_W` = 4.
- Sub-module `Decodificador10`: combinational 4-to-10 one-hot write-enable decoder.
  - Inputs: address, enable.
  - Outputs: 10-bit one-hot enable, plus an `invalido` flag for address > 9.
  - Shared between the write path and the clear sweep; the FSM muxes address/data into it.

## Test plan
- Reset, then write `Endereco`=3, `Dado`=0xA5 → `Reg3`=0xA5 the next cycle, all other registers 0, `Erro`=0.
- Writes 0..9 on consecutive cycles with data 0x10+N → after 10 cycles `RegN`=0x10+N; `Pronto` held high throughout.
- Write `Endereco`=12, `Dado`=0xFF → no register changes, `Erro`=1 for exactly one cycle.
- Registers loaded, then `Limpar` and `Valido` (addr 5, 0x77) asserted in the same cycle:
  - `Pronto`=0 and the write is not accepted.
  - `Ocupado` is high for 10 cycles and all registers end at 0.
  - `Reg5` ≠ 0x77.
- `Reset_n` low on the 4th cycle of a clear → all registers 0 and `Ocupado`=0 the next cycle; a write 2 cycles after reset release is accepted.
- With `BANCO_REG0_ZERO_EN`: write addr 0, 0x55 → `Reg0` stays 0, `Erro`=0.
